// File: rtl/radix2_divider.sv
// Radix-2 restoring divider: 32-bit signed/unsigned divide, one quotient bit per cycle.
// result = {remainder, quotient}; done is high whenever the block is idle.
module radix2_divider #(
   parameter logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  div_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [63:0] result,
   output logic        done
);

   localparam int unsigned W  = 32;
   localparam int unsigned CW = 5;

   localparam logic [1:0] OP_SIGNED   = 2'b10;
   localparam logic [1:0] OP_UNSIGNED = 2'b01;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            start_c;
   logic            is_signed_c;

   logic [CW-1:0]   cnt;
   logic [W:0]      rem;        // 33-bit partial remainder
   logic [W-1:0]    quo;        // dividend magnitude shifting out, quotient shifting in
   logic [W-1:0]    dsor;       // divisor magnitude
   logic [W-1:0]    orig_dvd;   // raw dividend, returned as remainder on divide-by-zero
   logic            neg_q;
   logic            neg_r;
   logic            div_zero;

   logic [W+1:0]    shift_c;
   logic [W:0]      diff_c;
   logic            ge_c;
   logic [W-1:0]    dvd_mag_c;
   logic [W-1:0]    dsr_mag_c;
   logic [W-1:0]    q_fix_c;
   logic [W-1:0]    r_fix_c;

   // State register; reset wins over any simultaneous request
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic and capture strobe
   always_comb begin
      state_nxt   = state;
      start_c     = 1'b0;
      is_signed_c = (div_op == OP_SIGNED);
      case (state)
         IDLE: begin
            if ((div_op == OP_SIGNED) || (div_op == OP_UNSIGNED)) begin
               start_c   = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == CW'(W - 1)) state_nxt = FIX;
         end
         FIX: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Operand magnitudes; the most negative value maps onto itself
   always_comb begin
      dvd_mag_c = (is_signed_c && dividend[W-1]) ? W'(-dividend) : dividend;
      dsr_mag_c = (is_signed_c && divisor[W-1])  ? W'(-divisor)  : divisor;
   end

   // One restoring shift-subtract step
   always_comb begin
      shift_c = {rem, quo[W-1]};
      ge_c    = (shift_c >= (W+2)'(dsor));
      diff_c  = shift_c[W:0] - (W+1)'(dsor);
   end

   // Sign correction and divide-by-zero override applied in FIX
   always_comb begin
      q_fix_c = neg_q ? W'(-quo) : quo;
      r_fix_c = neg_r ? W'(-rem[W-1:0]) : rem[W-1:0];
      if (div_zero) begin
         q_fix_c = DIVZERO_Q;
         r_fix_c = orig_dvd;
      end
   end

   // Datapath, iteration counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         rem      <= '0;
         quo      <= '0;
         dsor     <= '0;
         orig_dvd <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         result   <= '0;
         done     <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start_c) begin
                  cnt      <= '0;
                  rem      <= '0;
                  quo      <= dvd_mag_c;
                  dsor     <= dsr_mag_c;
                  orig_dvd <= dividend;
                  neg_q    <= is_signed_c && (dividend[W-1] ^ divisor[W-1]);
                  neg_r    <= is_signed_c && dividend[W-1];
                  div_zero <= (divisor == '0);
                  done     <= 1'b0;
               end
            end
            BUSY: begin
               rem <= ge_c ? diff_c : shift_c[W:0];
               quo <= {quo[W-2:0], ge_c};
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               result <= {r_fix_c, q_fix_c};
               done   <= 1'b1;
            end
            default: begin
               done <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench for radix2_divider: directed corner cases plus random
// operands checked against an arithmetic reference model.
module tb_radix2_divider;

   localparam logic [31:0] DZQ = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  div_op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic [63:0] result;
   logic        done;

   int total = 0;
   int bad   = 0;

   radix2_divider #(.DIVZERO_Q(DZQ)) dut (
      .clk      (clk),
      .rst      (rst),
      .div_op   (div_op),
      .dividend (dividend),
      .divisor  (divisor),
      .result   (result),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Single comparison point for the whole bench
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic, truncating signed division
   function automatic logic [63:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] q32, r32;
      if (b == 32'd0) return {a, DZQ};
      if (op == 2'b01) return {a % b, a / b};
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = sa / sb;
      r   = sa % sb;
      q32 = q[31:0];
      r32 = r[31:0];
      return {r32, q32};
   endfunction

   // Present a request for one capture edge; leave it asserted if hold is set
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
      logic [63:0] prev;
      @(negedge clk);
      div_op   = op;
      dividend = a;
      divisor  = b;
      prev     = result;
      @(negedge clk);
      if (!hold) div_op = 2'b00;
      check("done_low_after_capture", 64'(done), 64'd0);
      check("result_held_in_busy", result, prev);
   endtask

   // Count low cycles of done (bounded) and check latency and result
   task automatic wait_done(input string tag, input int pre, input logic [63:0] exp);
      int low = pre;
      while (!done && low < 100) begin
         low++;
         @(negedge clk);
      end
      check({tag, "_latency"}, 64'(low), 64'd33);
      check(tag, result, exp);
   endtask

   task automatic run_div(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      start_op(op, a, b, 1'b0);
      wait_done(tag, 0, ref_div(op, a, b));
   endtask

   initial begin
      logic [63:0] keep;
      logic [1:0]  op;
      logic [31:0] a, b;

      rst = 1'b1; div_op = 2'b00; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      check("reset_done", 64'(done), 64'd1);
      check("reset_result", result, 64'd0);
      rst = 1'b0;

      // Directed values
      run_div("u_100_7", 2'b01, 32'd100, 32'd7);
      check("u_100_7_const", result, {32'd2, 32'd14});
      run_div("s_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
      check("s_m7_2_const", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      run_div("s_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE);
      check("s_7_m2_const", result, {32'd1, 32'hFFFF_FFFD});
      run_div("u_divzero", 2'b01, 32'h1234, 32'd0);
      check("u_divzero_const", result, {32'h0000_1234, 32'hFFFF_FFFF});
      run_div("s_divzero", 2'b10, 32'hFFFF_FF00, 32'd0);
      check("s_divzero_const", result, {32'hFFFF_FF00, 32'hFFFF_FFFF});
      run_div("s_overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      check("s_overflow_const", result, {32'd0, 32'h8000_0000});
      run_div("u_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);
      check("u_max_1_const", result, {32'd0, 32'hFFFF_FFFF});

      // Request during BUSY is dropped
      start_op(2'b01, 32'd1000, 32'd3, 1'b0);
      repeat (9) @(negedge clk);
      div_op = 2'b10; dividend = 32'd55; divisor = 32'd5;
      @(negedge clk);
      div_op = 2'b00;
      wait_done("busy_ignore", 10, {32'd1, 32'd333});
      repeat (3) begin
         @(negedge clk);
         check("no_second_start", 64'(done), 64'd1);
      end

      // Op 11 in IDLE is a no-op
      keep = result;
      @(negedge clk);
      div_op = 2'b11;
      repeat (3) begin
         @(negedge clk);
         check("op11_done", 64'(done), 64'd1);
      end
      check("op11_result", result, keep);
      div_op = 2'b00;

      // Request held across completion restarts one edge after done rises
      start_op(2'b01, 32'd77, 32'd10, 1'b1);
      wait_done("restart_first", 0, {32'd7, 32'd7});
      @(negedge clk);
      check("restart_next_edge", 64'(done), 64'd0);
      div_op = 2'b00;
      wait_done("restart_second", 0, {32'd7, 32'd7});

      // Reset mid-iteration aborts and clears
      start_op(2'b01, 32'hDEAD_BEEF, 32'h13, 1'b0);
      repeat (15) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_done", 64'(done), 64'd1);
      check("midrst_result", result, 64'd0);
      rst = 1'b0;
      run_div("after_rst", 2'b01, 32'hDEAD_BEEF, 32'h13);

      // Reset beats a simultaneous start
      @(negedge clk);
      rst = 1'b1; div_op = 2'b01; dividend = 32'd9; divisor = 32'd2;
      @(negedge clk);
      rst = 1'b0; div_op = 2'b00;
      check("rst_prio_done", 64'(done), 64'd1);
      @(negedge clk);
      check("rst_prio_idle", 64'(done), 64'd1);
      check("rst_prio_result", result, 64'd0);

      // Random operands with biased divisors
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         a  = $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       b = 32'($urandom_range(1, 15));
            3:       a = 32'h8000_0000;
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         if (op == 2'b10 && $urandom_range(0, 1) == 1) b = -b;
         run_div("random", op, a, b);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
